vram_cpu_port: RTL and testbench

//  Initiator side of the VDC VRAM port: turns host register ops (MAWR, MARR, VWR, VRR) into re/we cycles on MA/MD.

---
 rtl/vram_cpu_port.sv | 134 +++++++++++++
 tb/tb_vram_cpu_port.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_cpu_port.sv
// Host-side VRAM initiator: MAWR/MARR/VWR/VRR register ops become single re/we cycles on MA/MD.
// Latency: write issues on first free slot after accept; read data lands in VRR one cycle after re.
// Backpressure: req_ready only in IDLE; a stalled slot holds the FSM with no op lost or queued.
module vram_cpu_port #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int VRAM_WORDS = 32768
) (
    input  logic              clock,
    input  logic              reset_N,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        inc_sel,
    input  logic              slot_free,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] MA,
    output logic              re,
    output logic              we,
    output logic [DATA_W-1:0] MD_out,
    input  logic [DATA_W-1:0] MD_in
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_ISSUE,
        S_RD_ISSUE,
        S_RD_CAPTURE
    } state_t;

    localparam logic [ADDR_W:0] VRAM_LIM = (ADDR_W+1)'(VRAM_WORDS);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] mawr, marr, step_q, ma_q;
    logic [DATA_W-1:0] vwr, vrr, md_q;
    logic              rd_pop_q;
    logic              accept, wr_pop, rd_pop;

    function automatic logic [ADDR_W-1:0] step_of(input logic [1:0] sel);
        case (sel)
            2'd0:    step_of = ADDR_W'(1);
            2'd1:    step_of = ADDR_W'(32);
            2'd2:    step_of = ADDR_W'(64);
            default: step_of = ADDR_W'(128);
        endcase
    endfunction

    assign accept = req_valid & req_ready;
    assign wr_pop = ({1'b0, mawr} < VRAM_LIM);
    assign rd_pop = ({1'b0, marr} < VRAM_LIM);

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        re        = 1'b0;
        we        = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    case (req_op)
                        2'd0:    state_nxt = S_IDLE;
                        2'd2:    state_nxt = S_WR_ISSUE;
                        default: state_nxt = S_RD_ISSUE;
                    endcase
                end
            end
            S_WR_ISSUE: begin
                if (slot_free) begin
                    we        = wr_pop;
                    state_nxt = S_IDLE;
                end
            end
            S_RD_ISSUE: begin
                if (slot_free) begin
                    re        = rd_pop;
                    state_nxt = S_RD_CAPTURE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The bus is only driven with a new address/data on an actual strobe; otherwise it holds.
    assign MA     = we ? mawr : (re ? marr : ma_q);
    assign MD_out = we ? vwr : md_q;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state    <= S_IDLE;
            mawr     <= '0;
            marr     <= '0;
            vwr      <= '0;
            vrr      <= '0;
            step_q   <= ADDR_W'(1);
            ma_q     <= '0;
            md_q     <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_pop_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            ma_q     <= MA;
            md_q     <= MD_out;
            rd_valid <= 1'b0;
            if (accept) begin
                step_q <= step_of(inc_sel);
                case (req_op)
                    2'd0: mawr <= ADDR_W'(req_data);
                    2'd1: marr <= ADDR_W'(req_data);
                    2'd2: vwr  <= req_data;
                    default: begin
                        rd_valid <= 1'b1;
                        rd_data  <= vrr;
                    end
                endcase
            end
            // Address advances even when the target is unpopulated and no strobe was issued.
            if (state == S_WR_ISSUE && slot_free) begin
                mawr <= mawr + step_q;
            end
            if (state == S_RD_ISSUE && slot_free) begin
                rd_pop_q <= rd_pop;
            end
            if (state == S_RD_CAPTURE) begin
                vrr  <= rd_pop_q ? MD_in : '0;
                marr <= marr + step_q;
            end
        end
    end

endmodule

// File: tb/tb_vram_cpu_port.sv
// Randomized bench for vram_cpu_port with an op-level reference model and a VRAM responder.
module tb_vram_cpu_port;

    localparam int WORDS = 32768;

    logic        clock = 1'b0;
    logic        reset_N;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [15:0] req_data;
    logic [1:0]  inc_sel;
    logic        slot_free;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [15:0] MA;
    logic        re;
    logic        we;
    logic [15:0] MD_out;
    logic [15:0] MD_in = '0;

    vram_cpu_port #(.ADDR_W(16), .DATA_W(16), .VRAM_WORDS(WORDS)) dut (
        .clock(clock), .reset_N(reset_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .inc_sel(inc_sel), .slot_free(slot_free),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .MA(MA), .re(re), .we(we), .MD_out(MD_out), .MD_in(MD_in)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;   // 0 write, 1 read strobe, 2 rd_valid
        logic [15:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t         evq[$];
    logic [15:0] vram [0:65535];
    logic [15:0] mmem [0:65535];
    logic [15:0] m_mawr, m_marr, m_vrr, m_step;
    int          total = 0;
    int          bad   = 0;
    int          slot_mode = 0;
    int          we_cnt = 0, re_cnt = 0;
    logic [15:0] last_we_addr = '0, last_we_data = '0, last_re_addr = '0, last_rd = '0;
    logic [15:0] prev_ma = '0, prev_md = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // VRAM responder: read data appears the cycle after re.
    always @(posedge clock) begin
        if (re) MD_in <= vram[MA];
        if (we) vram[MA] = MD_out;
    end

    always @(posedge clock) begin
        #1;
        case (slot_mode)
            0:       slot_free = 1'b1;
            1:       slot_free = ($urandom_range(0, 2) != 0);
            default: slot_free = 1'b0;
        endcase
    end

    task automatic expect_ev(input int kind, input logic [15:0] addr, input logic [15:0] data);
        ev_t e;
        if (evq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h want none", kind, addr, data);
        end else begin
            e = evq.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind != 2) chk("event_addr", addr, e.addr);
            if (kind != 1) chk("event_data", data, e.data);
        end
    endtask

    always @(negedge clock) begin
        if (reset_N === 1'b1) begin
            if (re || we) begin
                chk("re_we_exclusive", {31'b0, re & we}, 32'd0);
                chk("strobe_needs_slot", {31'b0, slot_free}, 32'd1);
            end
            if (rd_valid) begin
                last_rd = rd_data;
                expect_ev(2, 16'h0, rd_data);
            end
            if (we) begin
                we_cnt++;
                last_we_addr = MA;
                last_we_data = MD_out;
                expect_ev(0, MA, MD_out);
            end
            if (re) begin
                re_cnt++;
                last_re_addr = MA;
                expect_ev(1, MA, 16'h0);
            end
            if (!re && !we) begin
                chk("MA_hold", MA, prev_ma);
                chk("MD_hold", MD_out, prev_md);
            end
        end
        prev_ma = MA;
        prev_md = MD_out;
    end

    function automatic logic [15:0] step_val(input int inc);
        return (inc == 0) ? 16'd1 : 16'(16 << inc);
    endfunction

    task automatic model_read();
        if (m_marr < WORDS) begin
            evq.push_back('{1, m_marr, 16'h0});
            m_vrr = mmem[m_marr];
        end else begin
            m_vrr = 16'h0;
        end
        m_marr = m_marr + m_step;
    endtask

    task automatic model_op(input int op, input logic [15:0] d, input int inc);
        m_step = step_val(inc);
        case (op)
            0: m_mawr = d;
            1: begin
                m_marr = d;
                model_read();
            end
            2: begin
                if (m_mawr < WORDS) begin
                    evq.push_back('{0, m_mawr, d});
                    mmem[m_mawr] = d;
                end
                m_mawr = m_mawr + m_step;
            end
            default: begin
                evq.push_back('{2, 16'h0, m_vrr});
                model_read();
            end
        endcase
    endtask

    task automatic model_reset();
        m_mawr = '0;
        m_marr = '0;
        m_vrr  = '0;
        m_step = 16'd1;
        evq.delete();
    endtask

    task automatic do_op(input int op, input logic [15:0] d, input int inc);
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got req_ready=0 for %0d cycles want 1", n);
        end else begin
            model_op(op, d, inc);
            req_valid = 1'b1;
            req_op    = 2'(op);
            req_data  = d;
            inc_sel   = 2'(inc);
            @(posedge clock);
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 500) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: got req_ready=0 want 1");
        end
        @(negedge clock);
    endtask

    initial begin
        int          w0, r0, op, inc, sel;
        logic [15:0] d;
        reset_N   = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_data  = '0;
        inc_sel   = '0;
        slot_free = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            vram[i] = 16'($urandom);
            mmem[i] = vram[i];
        end
        vram[16'h0010] = 16'hBEEF; mmem[16'h0010] = 16'hBEEF;
        vram[16'h0011] = 16'hCAFE; mmem[16'h0011] = 16'hCAFE;
        model_reset();
        #1;
        chk("reset_ready", {31'b0, req_ready}, 32'd1);
        chk("reset_re", {31'b0, re}, 32'd0);
        chk("reset_we", {31'b0, we}, 32'd0);
        chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("reset_MA", MA, 32'h0);
        chk("reset_MD_out", MD_out, 32'h0);
        chk("reset_rd_data", rd_data, 32'h0);
        repeat (3) @(negedge clock);
        reset_N = 1'b1;

        // Prefetch and VRR readback
        do_op(1, 16'h0010, 0); wait_idle();
        chk("T1_re_addr", last_re_addr, 32'h0010);
        do_op(3, 16'h0, 0); wait_idle();
        chk("T3_rd_data", last_rd, 32'hBEEF);
        chk("T3_re_addr", last_re_addr, 32'h0011);
        do_op(3, 16'h0, 0); wait_idle();
        chk("T3_vrr_next", last_rd, 32'hCAFE);

        // Write with step 32
        do_op(0, 16'h0100, 1);
        do_op(2, 16'h1111, 1); wait_idle();
        chk("T2_we0_addr", last_we_addr, 32'h0100);
        chk("T2_we0_data", last_we_data, 32'h1111);
        do_op(2, 16'h2222, 1); wait_idle();
        chk("T2_we1_addr", last_we_addr, 32'h0120);
        chk("T2_we1_data", last_we_data, 32'h2222);
        do_op(2, 16'h3333, 0); wait_idle();
        chk("T2_mawr_after", last_we_addr, 32'h0140);

        // Unpopulated boundary and wrap
        do_op(0, 16'h7FFF, 0);
        w0 = we_cnt;
        do_op(2, 16'hAAAA, 0);
        do_op(2, 16'h5555, 0); wait_idle();
        chk("T4_we_count", we_cnt - w0, 32'd1);
        chk("T4_we_addr", last_we_addr, 32'h7FFF);
        r0 = re_cnt;
        do_op(1, 16'hFFFF, 0); wait_idle();
        chk("T4_no_re", re_cnt - r0, 32'd0);
        do_op(3, 16'h0, 0); wait_idle();
        chk("T4_vrr_zero", last_rd, 32'h0);
        chk("T4_marr_wrap", last_re_addr, 32'h0000);
        do_op(1, 16'hFFE0, 1);
        do_op(3, 16'h0, 0); wait_idle();
        chk("T4_wrap32", last_re_addr, 32'h0000);

        // Slot starvation during a write
        do_op(0, 16'h0200, 0);
        slot_mode = 2;
        do_op(2, 16'h4444, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("T5_we_stalled", {31'b0, we}, 32'd0);
            chk("T5_not_ready", {31'b0, req_ready}, 32'd0);
        end
        slot_mode = 0;
        @(negedge clock);
        chk("T5_we_first_slot", {31'b0, we}, 32'd1);
        chk("T5_we_addr", MA, 32'h0200);
        wait_idle();

        // Reset during RD_ISSUE
        slot_mode = 2;
        do_op(1, 16'h0020, 0);
        repeat (3) @(negedge clock);
        reset_N = 1'b0;
        #1;
        chk("T6_re", {31'b0, re}, 32'd0);
        chk("T6_we", {31'b0, we}, 32'd0);
        chk("T6_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("T6_MA", MA, 32'h0);
        chk("T6_MD_out", MD_out, 32'h0);
        chk("T6_ready", {31'b0, req_ready}, 32'd1);
        model_reset();
        repeat (2) @(negedge clock);
        reset_N   = 1'b1;
        slot_mode = 0;
        do_op(3, 16'h0, 0); wait_idle();
        chk("T6_vrr_cleared", last_rd, 32'h0);
        chk("T6_marr_cleared", last_re_addr, 32'h0);

        // Randomized ops against the model
        for (int k = 0; k < 400; k++) begin
            op  = $urandom_range(0, 3);
            inc = $urandom_range(0, 3);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       d = 16'($urandom);
                1:       d = 16'(16'h7F00 + $urandom_range(0, 255));
                2:       d = 16'(16'hFF00 + $urandom_range(0, 255));
                default: d = 16'($urandom_range(0, 63));
            endcase
            slot_mode = $urandom_range(0, 1);
            do_op(op, d, inc);
        end
        slot_mode = 0;
        wait_idle();
        chk("events_drained", evq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
